capture_frame_controller: RTL and testbench
===========================================

Name: capture_frame_controller

Overview:
- Sequences OV7670 frame capture in the PCLK domain, between the pixel capture/downsampler datapath and the dual-port frame RAM write port.
- Arms on request and aligns to a frame boundary so a partial frame is never stored.
- Gates byte-wide pixel strobes into RAM writes with row/column address generation and clips to the frame size.
- Reports frame completion, geometry errors and a frame count; supports single-shot and continuous modes.

Parameters:
H_PIX, 160, pixels per line stored
V_LINES, 120, lines per frame stored
ADDR_W, 15, RAM address width; must hold H_PIX*V_LINES-1

Ports:
PCLK  in  1  camera pixel clock, the only clock; all logic on rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  capture request, sampled only in IDLE
CONTINUOUS  in  1  1: re-arm automatically after each frame
ABORT  in  1  cancel capture, any state
VSYNC  in  1  camera vertical sync, high between frames
HREF  in  1  camera line-valid
PX_VALID  in  1  datapath strobe: PX_DATA holds one finished pixel
PX_DATA  in  8  RGB332 pixel from datapath
RAM_DATA  out  8  write data to frame RAM
RAM_ADDR  out  ADDR_W  write address to frame RAM
RAM_WE  out  1  write enable, one cycle per stored pixel
BUSY  out  1  high from accepted START until return to IDLE
FRAME_DONE  out  1  one-cycle pulse per completed frame
FRAME_ERR  out  1  sticky geometry error, cleared on accepted START
FRAME_CNT  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset: state IDLE; all outputs 0; internal vs_q, href_q, col, row and line_base cleared to 0.
- Edge detect: registered vs_q and href_q. VS_FALL = vs_q & ~VSYNC. VS_RISE = ~vs_q & VSYNC. HREF_FALL = href_q & ~HREF.
- States: IDLE, WAIT_VS, CAPTURE, DONE.
- IDLE: BUSY=0. START=1 -> WAIT_VS; set BUSY=1, clear FRAME_ERR, col, row and line_base.
- WAIT_VS: wait for VS_FALL -> CAPTURE. A START issued mid-frame therefore waits for the next frame. Pixels are ignored in this state.
- CAPTURE pixel accept: HREF & PX_VALID & col<H_PIX & row<V_LINES.
  - Next cycle: RAM_WE=1, RAM_ADDR=line_base+col, RAM_DATA=PX_DATA. Latency is 1 cycle.
  - col increments by 1 per accepted pixel.
  - PX_VALID with HREF=0 is ignored and does not set an error.
- Clipping: a PX_VALID with HREF=1 and col>=H_PIX or row>=V_LINES is dropped, with no write, and sets FRAME_ERR.
- On HREF_FALL with col!=0:
  - FRAME_ERR is set if col!=H_PIX (short line).
  - row increments, saturating at V_LINES; line_base increases by H_PIX; col is cleared.
  - HREF_FALL with col==0 is ignored.
- CAPTURE to DONE on VS_RISE. FRAME_ERR is set if row!=V_LINES.
- If HREF_FALL and VS_RISE occur in the same cycle, the line close is applied first and the row check uses the updated row.
- DONE (one cycle):
  - FRAME_DONE=1; FRAME_CNT += 1 with wrap.
  - CONTINUOUS=1 -> WAIT_VS with BUSY held, and col/row/line_base cleared; FRAME_ERR is not cleared.
  - Else -> IDLE.
- ABORT has priority over everything, in all states:
  - Next state IDLE, RAM_WE forced 0 next cycle, BUSY=0 next cycle.
  - No FRAME_DONE; FRAME_CNT and FRAME_ERR are unchanged.
  - ABORT and START together: stay or go IDLE.
- START outside IDLE is ignored.
- RAM_WE is 0 in every cycle without an accept in the previous cycle. RAM_ADDR/RAM_DATA hold their last value when RAM_WE=0.
- Asynchronous reset asserted mid-capture: immediate return to reset values. A pending write is lost.

Test Plan:
- H_PIX=4, V_LINES=3; START, then a clean frame (3 lines x 4 pixels, data 0x10..0x1B) -> 12 writes at addr 0..11 with matching data, one FRAME_DONE, FRAME_ERR=0, FRAME_CNT=1, BUSY=0 after DONE.
- START asserted while VSYNC low and HREF active mid-frame -> no writes until after the next VS_FALL; then a full frame is stored from addr 0.
- Line 1 has 5 pixels and line 2 has 3 pixels -> 5th pixel dropped; line 2 writes at addr 8..10; FRAME_ERR=1; FRAME_DONE still pulses.
- CONTINUOUS=1 over 3 clean frames -> 3 FRAME_DONE pulses; each frame restarts at addr 0; BUSY stays 1; FRAME_CNT=3. Preload FRAME_CNT=255 and run one more frame -> FRAME_CNT=0.
- ABORT during line 2 -> RAM_WE=0 from the next cycle, IDLE, no FRAME_DONE, FRAME_CNT unchanged. A later START captures a full frame correctly.
- RST_N low mid-line for less than one PCLK period -> all outputs 0 immediately. PX_VALID with HREF=0 in CAPTURE -> no write, no error.

Source files
------------

// File: rtl/capture_frame_controller.sv
// Frame capture sequencer for an OV7670 pixel stream: aligns to a frame boundary,
// turns pixel strobes into frame-RAM writes, and reports completion, geometry errors and frame count.
module capture_frame_controller #(
  parameter int H_PIX   = 160,
  parameter int V_LINES = 120,
  parameter int ADDR_W  = 15
) (
  input  logic              PCLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              CONTINUOUS,
  input  logic              ABORT,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic              PX_VALID,
  input  logic [7:0]        PX_DATA,
  output logic [7:0]        RAM_DATA,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WE,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              FRAME_ERR,
  output logic [7:0]        FRAME_CNT
);

  localparam int COL_W = $clog2(H_PIX + 1);
  localparam int ROW_W = $clog2(V_LINES + 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

  state_t            state;
  logic              vs_q;
  logic              href_q;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] line_base;

  logic             vs_fall, vs_rise, href_fall;
  logic             col_ok, row_ok, accept, clip;
  logic             line_close, short_line, row_short;
  logic [ROW_W-1:0] row_closed;

  always_comb begin
    vs_fall    = vs_q & ~VSYNC;
    vs_rise    = ~vs_q & VSYNC;
    href_fall  = href_q & ~HREF;
    col_ok     = (col < COL_W'(H_PIX));
    row_ok     = (row < ROW_W'(V_LINES));
    accept     = HREF & PX_VALID & col_ok & row_ok;
    clip       = HREF & PX_VALID & ~(col_ok & row_ok);
    line_close = href_fall & (col != '0);
    short_line = (col != COL_W'(H_PIX));
    // The row count used by the end-of-frame check must include a line closing in the same cycle.
    row_closed = (line_close && row_ok) ? row + 1'b1 : row;
    row_short  = (row_closed != ROW_W'(V_LINES));
  end

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      vs_q       <= 1'b0;
      href_q     <= 1'b0;
      col        <= '0;
      row        <= '0;
      line_base  <= '0;
      RAM_DATA   <= '0;
      RAM_ADDR   <= '0;
      RAM_WE     <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
      FRAME_CNT  <= '0;
    end else begin
      vs_q       <= VSYNC;
      href_q     <= HREF;
      RAM_WE     <= 1'b0;
      FRAME_DONE <= 1'b0;
      if (ABORT) begin
        state <= IDLE;
        BUSY  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (START) begin
              state     <= WAIT_VS;
              BUSY      <= 1'b1;
              FRAME_ERR <= 1'b0;
              col       <= '0;
              row       <= '0;
              line_base <= '0;
            end
          end
          WAIT_VS: begin
            if (vs_fall) state <= CAPTURE;
          end
          CAPTURE: begin
            if (accept) begin
              RAM_WE   <= 1'b1;
              RAM_ADDR <= line_base + ADDR_W'(col);
              RAM_DATA <= PX_DATA;
              col      <= col + 1'b1;
            end
            if (line_close) begin
              col <= '0;
              row <= row_closed;
              if (row_ok) line_base <= line_base + ADDR_W'(H_PIX);
            end
            if (clip || (line_close && short_line) || (vs_rise && row_short))
              FRAME_ERR <= 1'b1;
            if (vs_rise) begin
              state      <= DONE;
              FRAME_DONE <= 1'b1;
              FRAME_CNT  <= FRAME_CNT + 1'b1;
            end
          end
          DONE: begin
            if (CONTINUOUS) begin
              state     <= WAIT_VS;
              col       <= '0;
              row       <= '0;
              line_base <= '0;
            end else begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_frame_controller.sv
// Directed-plus-random bench for capture_frame_controller with a small 4x3 frame geometry.
module tb_capture_frame_controller;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 15;

  logic          PCLK = 1'b0;
  logic          RST_N, START, CONTINUOUS, ABORT, VSYNC, HREF, PX_VALID;
  logic [7:0]    PX_DATA;
  logic [7:0]    RAM_DATA;
  logic [AW-1:0] RAM_ADDR;
  logic          RAM_WE, BUSY, FRAME_DONE, FRAME_ERR;
  logic [7:0]    FRAME_CNT;

  capture_frame_controller #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .PCLK(PCLK), .RST_N(RST_N), .START(START), .CONTINUOUS(CONTINUOUS), .ABORT(ABORT),
    .VSYNC(VSYNC), .HREF(HREF), .PX_VALID(PX_VALID), .PX_DATA(PX_DATA),
    .RAM_DATA(RAM_DATA), .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .BUSY(BUSY),
    .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR), .FRAME_CNT(FRAME_CNT)
  );

  always #5 PCLK = ~PCLK;

  int          total = 0;
  int          passed = 0;
  int          done_seen = 0;
  int          exp_done = 0;
  logic [7:0]  exp_cnt = 8'd0;
  logic        exp_err = 1'b0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          len[3];
  bit          seq_data = 1'b0;

  always @(negedge PCLK) begin
    if (RAM_WE === 1'b1) got_q.push_back(32'({RAM_ADDR, RAM_DATA}));
    if (FRAME_DONE === 1'b1) done_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic cyc();
    @(negedge PCLK);
  endtask

  // A frame is faulty unless every nonempty line is exactly H pixels and exactly V such lines arrive.
  function automatic logic frame_err();
    int nonempty = 0;
    logic bad = 1'b0;
    for (int l = 0; l < 3; l++)
      if (len[l] > 0) begin
        nonempty++;
        if (len[l] != H) bad = 1'b1;
      end
    return bad | (nonempty != V);
  endfunction

  task automatic set_clean();
    for (int l = 0; l < 3; l++) len[l] = H;
  endtask

  task automatic start_cmd();
    START = 1'b1;
    cyc();
    START = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic drive_frame(input int start_line, input int abort_line, input bit record, input bit noise);
    bit         aborted = 1'b0;
    int         k = 0;
    logic [7:0] d;
    VSYNC = 1'b1;
    repeat (3) cyc();
    VSYNC = 1'b0;
    repeat (2) cyc();
    for (int l = 0; l < 3; l++) begin
      HREF = 1'b1;
      for (int j = 0; j < len[l]; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          PX_VALID = 1'b0;
          cyc();
        end
        if (l == abort_line && j == 2) begin
          PX_VALID = 1'b0;
          ABORT = 1'b1;
          cyc();
          ABORT = 1'b0;
          check("abort_we", 32'(RAM_WE), 32'd0);
          check("abort_busy", 32'(BUSY), 32'd0);
          aborted = 1'b1;
        end
        d = seq_data ? 8'h10 + 8'(k) : 8'($urandom);
        k++;
        PX_VALID = 1'b1;
        PX_DATA = d;
        if (l == start_line && j == 0) START = 1'b1;
        if (record && !aborted && l < V && j < H) exp_q.push_back(32'({AW'(l * H + j), d}));
        cyc();
        START = 1'b0;
      end
      PX_VALID = 1'b0;
      HREF = 1'b0;
      cyc();
      if (noise) begin
        PX_VALID = 1'b1;
        PX_DATA = 8'($urandom);
        cyc();
        PX_VALID = 1'b0;
      end
      cyc();
    end
    VSYNC = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_wr"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic post_frame(input string tag, input logic busy_exp);
    exp_done++;
    exp_cnt = exp_cnt + 8'd1;
    exp_err = exp_err | frame_err();
    check_writes(tag);
    check({tag, "_done"}, 32'(done_seen), 32'(exp_done));
    check({tag, "_cnt"}, 32'(FRAME_CNT), 32'(exp_cnt));
    check({tag, "_err"}, 32'(FRAME_ERR), 32'(exp_err));
    check({tag, "_busy"}, 32'(BUSY), 32'(busy_exp));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 32'(RAM_WE), 32'd0);
    check({tag, "_addr"}, 32'(RAM_ADDR), 32'd0);
    check({tag, "_data"}, 32'(RAM_DATA), 32'd0);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_done"}, 32'(FRAME_DONE), 32'd0);
    check({tag, "_err"}, 32'(FRAME_ERR), 32'd0);
    check({tag, "_cnt"}, 32'(FRAME_CNT), 32'd0);
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; CONTINUOUS = 1'b0; ABORT = 1'b0;
    VSYNC = 1'b0; HREF = 1'b0; PX_VALID = 1'b0; PX_DATA = 8'd0;
    repeat (3) cyc();
    check_all_zero("reset");
    RST_N = 1'b1;
    cyc();

    // Clean single-shot frame with sequential data 0x10..0x1B.
    set_clean();
    seq_data = 1'b1;
    start_cmd();
    drive_frame(-1, -1, 1'b1, 1'b0);
    seq_data = 1'b0;
    post_frame("clean", 1'b0);

    // START mid-frame: nothing stored until the following frame.
    exp_err = 1'b0;
    drive_frame(1, -1, 1'b0, 1'b0);
    check_writes("midstart_skip");
    check("midstart_busy", 32'(BUSY), 32'd1);
    check("midstart_nodone", 32'(done_seen), 32'(exp_done));
    drive_frame(-1, -1, 1'b1, 1'b0);
    post_frame("midstart", 1'b0);

    // Long line then short line.
    len[0] = 4; len[1] = 5; len[2] = 3;
    start_cmd();
    drive_frame(-1, -1, 1'b1, 1'b0);
    post_frame("geom", 1'b0);

    // Continuous mode: three clean frames, then run on to the counter wrap.
    set_clean();
    CONTINUOUS = 1'b1;
    start_cmd();
    for (int f = 0; f < 3; f++) begin
      drive_frame(-1, -1, 1'b1, 1'b0);
      post_frame("cont", 1'b1);
    end
    while (exp_cnt != 8'd255) begin
      for (int l = 0; l < 3; l++)
        len[l] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 6)) : H;
      drive_frame(-1, -1, 1'b1, 1'b0);
      post_frame("bulk", 1'b1);
    end
    set_clean();
    CONTINUOUS = 1'b0;
    drive_frame(-1, -1, 1'b1, 1'b0);
    post_frame("wrap", 1'b0);

    // Abort during the second line, then a fresh capture with HREF-low strobes mixed in.
    start_cmd();
    drive_frame(-1, 1, 1'b1, 1'b0);
    check_writes("abort");
    check("abort_nodone", 32'(done_seen), 32'(exp_done));
    check("abort_cnt", 32'(FRAME_CNT), 32'(exp_cnt));
    check("abort_err", 32'(FRAME_ERR), 32'(exp_err));
    check("abort_idle", 32'(BUSY), 32'd0);
    start_cmd();
    drive_frame(-1, -1, 1'b1, 1'b1);
    post_frame("recap", 1'b0);

    // Short asynchronous reset with a write in flight.
    start_cmd();
    VSYNC = 1'b1;
    repeat (2) cyc();
    VSYNC = 1'b0;
    repeat (2) cyc();
    HREF = 1'b1;
    PX_VALID = 1'b1;
    PX_DATA = 8'hA5;
    @(posedge PCLK);
    #1;
    check("prerst_we", 32'(RAM_WE), 32'd1);
    RST_N = 1'b0;
    #1;
    check_all_zero("async_rst");
    #1;
    RST_N = 1'b1;
    repeat (3) cyc();
    HREF = 1'b0;
    PX_VALID = 1'b0;
    cyc();
    check("rst_lost_writes", 32'(got_q.size()), 32'd0);
    check("rst_idle", 32'(BUSY), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
